card_deck_dealer: RTL and testbench

//  Upstream dealer for the card display stage: holds one 52-card deck and deals

---
 rtl/card_pkg.sv | 28 ++
 rtl/card_index_decode.sv | 30 +++
 rtl/card_deck_dealer.sv | 93 +++++++++
 tb/tb_card_deck_dealer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared card definitions: deck geometry, rank/suit types,
// dealer FSM states and the draw LFSR step function.
package card_pkg;

    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;
    localparam int SUITS     = 4;

    localparam logic [5:0]  DECK_CNT  = 6'd52;
    localparam logic [5:0]  LAST_IDX  = 6'd51;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef logic [3:0] rank_t;
    typedef logic [1:0] suit_t;
    typedef logic [5:0] idx_t;
    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_DRAW    = 2'd1;
    localparam state_t S_PROBE   = 2'd2;
    localparam state_t S_PRESENT = 2'd3;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

endpackage

// File: rtl/card_index_decode.sv
// Card index (0..51) to rank 1..13 and suit 0..3, no divider.
// Ports: idx in; rank, suit out (combinational).
module card_index_decode
    import card_pkg::*;
(
    input  idx_t  idx,
    output rank_t rank,
    output suit_t suit
);

    idx_t rem;

    // Suit boundaries sit at 13, 26 and 39.
    always_comb begin
        suit = 2'd0;
        rem  = idx;
        if (idx >= 6'd39) begin
            suit = 2'd3;
            rem  = idx - 6'd39;
        end else if (idx >= 6'd26) begin
            suit = 2'd2;
            rem  = idx - 6'd26;
        end else if (idx >= 6'd13) begin
            suit = 2'd1;
            rem  = idx - 6'd13;
        end
        rank = rem[3:0] + 4'd1;
    end

endmodule

// File: rtl/card_deck_dealer.sv
// 52-card dealer: draws without replacement via LFSR + linear probe.
// Ports: clock, reset(n), shuffle_req, deal_req, card_ready in;
//        card_valid/rank/suit, cards_left, deck_empty, busy out.
module card_deck_dealer
    import card_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       shuffle_req,
    input  logic       deal_req,
    input  logic       card_ready,
    output logic       card_valid,
    output rank_t      card_rank,
    output suit_t      card_suit,
    output logic [5:0] cards_left,
    output logic       deck_empty,
    output logic       busy
);

    state_t        state;
    logic [15:0]   lfsr;
    logic [51:0]   used;
    idx_t          idx;
    rank_t         dec_rank;
    suit_t         dec_suit;

    card_index_decode u_decode (
        .idx  (idx),
        .rank (dec_rank),
        .suit (dec_suit)
    );

    assign deck_empty = (cards_left == 6'd0);
    assign busy       = (state == S_DRAW) || (state == S_PROBE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            lfsr       <= LFSR_SEED;
            used       <= '0;
            idx        <= '0;
            card_valid <= 1'b0;
            card_rank  <= '0;
            card_suit  <= '0;
            cards_left <= DECK_CNT;
        end else begin
            lfsr <= lfsr_step(lfsr);
            // Shuffle overrides everything; an accepted card stays with
            // the consumer since rank/suit are simply held.
            if (shuffle_req) begin
                used       <= '0;
                cards_left <= DECK_CNT;
                card_valid <= 1'b0;
                state      <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (deal_req && cards_left != 6'd0)
                            state <= S_DRAW;
                    end
                    S_DRAW: begin
                        if (lfsr[5:0] < DECK_CNT) begin
                            idx   <= lfsr[5:0];
                            state <= S_PROBE;
                        end
                    end
                    S_PROBE: begin
                        if (used[idx]) begin
                            idx <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
                        end else begin
                            card_rank  <= dec_rank;
                            card_suit  <= dec_suit;
                            card_valid <= 1'b1;
                            state      <= S_PRESENT;
                        end
                    end
                    S_PRESENT: begin
                        if (card_ready) begin
                            used[idx]  <= 1'b1;
                            cards_left <= cards_left - 6'd1;
                            card_valid <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_card_deck_dealer.sv
// Self-checking bench for card_deck_dealer.
// Ports: none (drives clock, reset and handshake of the DUT).
module tb_card_deck_dealer;
    import card_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       shuffle_req = 1'b0;
    logic       deal_req = 1'b0;
    logic       card_ready = 1'b0;
    logic       card_valid;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       busy;

    logic [5:0] dec_idx;
    logic [3:0] dec_rank;
    logic [1:0] dec_suit;

    int n_cmp = 0;
    int n_err = 0;
    bit seen [52];
    int model_left;

    always #5 clock = ~clock;

    card_deck_dealer #(.LFSR_SEED(16'hACE1)) dut (
        .clock       (clock),
        .reset       (reset),
        .shuffle_req (shuffle_req),
        .deal_req    (deal_req),
        .card_ready  (card_ready),
        .card_valid  (card_valid),
        .card_rank   (card_rank),
        .card_suit   (card_suit),
        .cards_left  (cards_left),
        .deck_empty  (deck_empty),
        .busy        (busy)
    );

    card_index_decode u_dec (
        .idx  (dec_idx),
        .rank (dec_rank),
        .suit (dec_suit)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        foreach (seen[i]) seen[i] = 1'b0;
        model_left = 52;
    endtask

    // Index of the only card the model still holds, -1 if not unique.
    function automatic int sole_left();
        int k = -1;
        int n = 0;
        for (int i = 0; i < 52; i++)
            if (!seen[i]) begin
                k = i;
                n++;
            end
        return (n == 1) ? k : -1;
    endfunction

    // Record the presented card in the model; returns its index.
    task automatic take_card(output int key);
        int r = int'(card_rank);
        int s = int'(card_suit);
        chk("rank_range", (r >= 1 && r <= 13), 1);
        key = (r >= 1 && r <= 13) ? (r - 1) + 13 * s : 0;
        chk("distinct", seen[key], 0);
        seen[key] = 1'b1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (card_valid !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        chk("valid_seen", card_valid, 1);
    endtask

    task automatic deal_one(input bit stall);
        int cyc;
        int key;
        int expk;
        int nst;
        logic [3:0] r0;
        logic [1:0] s0;
        expk = sole_left();
        deal_req = 1'b1;
        card_ready = 1'b0;
        wait_valid(cyc);
        chk("latency_ge3", (cyc >= 3), 1);
        chk("busy_present", busy, 0);
        r0 = card_rank;
        s0 = card_suit;
        take_card(key);
        if (expk >= 0) chk("last_card", key, expk);
        nst = stall ? int'($urandom_range(0, 3)) : 0;
        for (int k = 0; k < nst; k++) begin
            tick();
            chk("stall_rank", card_rank, r0);
            chk("stall_left", cards_left, model_left);
        end
        card_ready = 1'b1;
        tick();
        card_ready = 1'b0;
        model_left--;
        chk("left_dec", cards_left, model_left);
        chk("valid_drop", card_valid, 0);
        chk("empty_flag", deck_empty, (model_left == 0));
    endtask

    initial begin
        int cyc;
        int key;
        bit bad;
        logic [3:0] r0;
        logic [1:0] s0;

        // decoder table
        for (int i = 0; i < 52; i++) begin
            dec_idx = 6'(i);
            #1;
            chk("dec_rank", dec_rank, (i % 13) + 1);
            chk("dec_suit", dec_suit, i / 13);
        end

        // reset values
        tick();
        tick();
        chk("rst_valid", card_valid, 0);
        chk("rst_rank", card_rank, 0);
        chk("rst_suit", card_suit, 0);
        chk("rst_left", cards_left, 52);
        chk("rst_empty", deck_empty, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        tick();

        // full deal with random consumer stalls
        clear_model();
        for (int n = 0; n < 52; n++) deal_one(1'b1);
        chk("full_empty", deck_empty, 1);
        chk("full_left", cards_left, 0);

        // requests against an empty deck
        deal_req = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (card_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("empty_idle", bad, 0);
        chk("empty_left", cards_left, 0);
        deal_req = 1'b0;

        shuffle_req = 1'b1;
        tick();
        shuffle_req = 1'b0;
        chk("shuf_left", cards_left, 52);
        chk("shuf_empty", deck_empty, 0);
        clear_model();

        // long backpressure hold
        deal_req = 1'b1;
        wait_valid(cyc);
        deal_req = 1'b0;
        r0 = card_rank;
        s0 = card_suit;
        take_card(key);
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (card_rank !== r0 || card_suit !== s0 ||
                cards_left !== 6'd52 || card_valid !== 1'b1)
                bad = 1'b1;
        end
        chk("hold_stable", bad, 0);
        card_ready = 1'b1;
        tick();
        card_ready = 1'b0;
        model_left--;
        chk("hold_dec", cards_left, 51);
        repeat (5) tick();
        chk("hold_once", cards_left, 51);
        chk("hold_rank", card_rank, r0);

        // shuffle during PRESENT after 51 dealt
        for (int n = 0; n < 50; n++) deal_one(1'b0);
        chk("pre51_left", cards_left, 1);
        deal_req = 1'b1;
        wait_valid(cyc);
        deal_req = 1'b0;
        shuffle_req = 1'b1;
        tick();
        shuffle_req = 1'b0;
        chk("sp_valid", card_valid, 0);
        chk("sp_left", cards_left, 52);
        chk("sp_busy", busy, 0);
        clear_model();
        for (int n = 0; n < 52; n++) deal_one(1'b1);
        chk("re_empty", deck_empty, 1);
        deal_req = 1'b0;

        // shuffle coinciding with a transfer
        shuffle_req = 1'b1;
        tick();
        shuffle_req = 1'b0;
        deal_req = 1'b1;
        wait_valid(cyc);
        deal_req = 1'b0;
        r0 = card_rank;
        s0 = card_suit;
        shuffle_req = 1'b1;
        card_ready = 1'b1;
        tick();
        shuffle_req = 1'b0;
        card_ready = 1'b0;
        chk("st_left", cards_left, 52);
        chk("st_valid", card_valid, 0);
        chk("st_rank", card_rank, r0);
        chk("st_suit", card_suit, s0);

        // asynchronous reset while probing
        deal_req = 1'b1;
        cyc = 0;
        while (dut.state !== S_PROBE && cyc < 300) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("probe_seen", dut.state, S_PROBE);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", card_valid, 0);
        chk("ar_rank", card_rank, 0);
        chk("ar_suit", card_suit, 0);
        chk("ar_left", cards_left, 52);
        chk("ar_empty", deck_empty, 0);
        chk("ar_busy", busy, 0);
        chk("ar_lfsr", dut.lfsr, 16'hACE1);
        deal_req = 1'b0;
        tick();
        reset = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (card_valid !== 1'b0) bad = 1'b1;
        end
        chk("ar_nocard", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
